// File: rtl/gen_arb_pkg.sv
// Shared types and width helpers for the streaming
// generator arbiter and its round-robin picker.
package gen_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      STREAM = 2'd2,
      CLEAR  = 2'd3
   } arb_state_t;

   // Never returns 0 so a 1-entry field still gets a bit.
   function automatic int clog2_min1(input int v);
      return (v > 1) ? $clog2(v) : 1;
   endfunction

endpackage

// File: rtl/gen_stream_arbiter_if.sv
// Client-fabric and generator-core signal bundle of the
// stream arbiter; master is the arbiter's own view.
interface gen_arb_if
   import gen_arb_pkg::*;
#(
   parameter int N  = 4,
   parameter int DW = 32
);
   localparam int IW = clog2_min1(N);

   logic [N-1:0]    req;
   logic [N*DW-1:0] req_n;
   logic [N-1:0]    cl_ready;
   logic [N-1:0]    cl_valid;
   logic [N-1:0]    cl_done;
   logic [DW-1:0]   cl_data;
   logic [IW-1:0]   grant_id;
   logic            busy;
   logic            trunc;
   logic [DW-1:0]   gen_n;
   logic            gen_start;
   logic            gen_clear;
   logic            gen_ready;
   logic            gen_valid;
   logic            gen_done;
   logic [DW-1:0]   gen_out;

   modport master (
      input  req, req_n, cl_ready,
      input  gen_valid, gen_done, gen_out,
      output cl_valid, cl_done, cl_data,
      output grant_id, busy, trunc,
      output gen_n, gen_start, gen_clear, gen_ready
   );

   modport slave (
      output req, req_n, cl_ready,
      output gen_valid, gen_done, gen_out,
      input  cl_valid, cl_done, cl_data,
      input  grant_id, busy, trunc,
      input  gen_n, gen_start, gen_clear, gen_ready
   );

endinterface

// File: rtl/gen_stream_arbiter_rr_arbiter.sv
// Combinational round-robin picker: lowest requesting
// index at or after the pointer wins.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [IW-1:0] gnt_id_o,
   output logic          any_o
);

   logic found;
   int   j;

   assign any_o = |req_i;

   always_comb begin
      gnt_id_o = '0;
      found    = 1'b0;
      j        = 0;
      for (int k = 0; k < N; k++) begin
         j = int'(ptr_i) + k;
         if (j >= N) j = j - N;
         if (!found && req_i[j]) begin
            gnt_id_o = IW'(j);
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/gen_stream_arbiter.sv
// Shares one streaming generator among N clients:
// round-robin grant, argument load, routed stream, re-arm.
module gen_stream_arbiter
   import gen_arb_pkg::*;
#(
   parameter int N_CLIENTS = 4,
   parameter int DATA_W    = 32,
   parameter int MAX_BEATS = 1024
) (
   input logic       clock,
   input logic       reset,
   gen_arb_if.master bus
);

   localparam int IW = clog2_min1(N_CLIENTS);
   localparam int CW = clog2_min1(MAX_BEATS + 1);
   localparam logic [IW-1:0] LAST_ID = IW'(N_CLIENTS - 1);
   localparam logic [CW-1:0] WD_LIM  = CW'(MAX_BEATS - 1);

   arb_state_t        state_q, state_d;
   logic [IW-1:0]     ptr_q, ptr_d;
   logic [IW-1:0]     gid_q, gid_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [DATA_W-1:0] gen_n_q, gen_n_d;
   logic              trunc_q, trunc_d;

   logic [IW-1:0]        win_id;
   logic                 win_any;
   logic                 stream;
   logic                 xfer;
   logic                 at_lim;
   logic [N_CLIENTS-1:0] own;

   rr_arbiter #(
      .N  (N_CLIENTS),
      .IW (IW)
   ) u_rr (
      .req_i    (bus.req),
      .ptr_i    (ptr_q),
      .gnt_id_o (win_id),
      .any_o    (win_any)
   );

   assign stream = (state_q == STREAM);
   assign own    = N_CLIENTS'(1) << gid_q;
   assign at_lim = (cnt_q == WD_LIM);
   assign xfer   = stream & bus.gen_valid & bus.gen_ready;

   assign gen_n_d = (state_q == LOAD)
                  ? bus.req_n[int'(gid_q)*DATA_W +: DATA_W]
                  : gen_n_q;

   assign bus.busy      = (state_q != IDLE);
   assign bus.grant_id  = gid_q;
   assign bus.trunc     = trunc_q;
   assign bus.gen_start = (state_q == LOAD);
   assign bus.gen_clear = (state_q == CLEAR);
   assign bus.gen_n     = gen_n_d;
   assign bus.gen_ready = stream & bus.cl_ready[gid_q];
   assign bus.cl_data   = stream ? bus.gen_out : '0;
   assign bus.cl_valid  = (stream & bus.gen_valid) ? own : '0;
   // Watchdog limit forces the last-beat flag on the capped beat.
   assign bus.cl_done   = (stream & bus.gen_valid &
                           (bus.gen_done | at_lim)) ? own : '0;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gid_d   = gid_q;
      cnt_d   = cnt_q;
      trunc_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (win_any) begin
               gid_d   = win_id;
               ptr_d   = (win_id == LAST_ID) ? '0 : win_id + 1'b1;
               state_d = LOAD;
            end
         end
         LOAD: state_d = STREAM;
         STREAM: begin
            if (xfer) begin
               cnt_d = cnt_q + 1'b1;
               if (bus.gen_done) begin
                  state_d = CLEAR;
               end else if (at_lim) begin
                  trunc_d = 1'b1;
                  state_d = CLEAR;
               end
            end
         end
         CLEAR: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         gid_q   <= '0;
         cnt_q   <= '0;
         gen_n_q <= '0;
         trunc_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gid_q   <= gid_d;
         cnt_q   <= cnt_d;
         gen_n_q <= gen_n_d;
         trunc_q <= trunc_d;
      end
   end

endmodule
